// File: rtl/router_link_pkg.sv
// router_link_pkg
// Shared types and constants for the router link transmitter slice.
//   link_tx_state_t : transmitter FSM states (IDLE, SEND, GAP)
//   DEF_DATA_W      : default flit width
//   DEF_FIFO_DEPTH  : default flit buffer depth
//   cnt_width()     : bits needed to hold an occupancy count of 0..depth
package router_link_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } link_tx_state_t;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_FIFO_DEPTH = 4;

    // Width of a counter that must represent every value from 0 to depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/router_link_oreq_tx_if.sv
// router_link_oreq_tx_if
// Bundles the router-side flit handshake and the inter-tile OREQ/IACK link.
//   in_valid/in_ready/in_data : flit offered by the router output stage
//   link_req/link_data        : level request and payload towards the receiver
//   link_ack                  : one-cycle registered acknowledge from the receiver
// Modports:
//   master : the transmitter block
//   slave  : the surrounding router/receiver environment
interface router_link_oreq_tx_if #(
    parameter int DATA_W = router_link_pkg::DEF_DATA_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              link_req;
    logic [DATA_W-1:0] link_data;
    logic              link_ack;

    modport master (
        input  in_valid,
        input  in_data,
        input  link_ack,
        output in_ready,
        output link_req,
        output link_data
    );

    modport slave (
        output in_valid,
        output in_data,
        output link_ack,
        input  in_ready,
        input  link_req,
        input  link_data
    );

endinterface

// File: rtl/router_link_fifo.sv
// router_link_fifo
// Synchronous flit FIFO for the link transmitter.
//   clk, reset : rising-edge clock, synchronous active-low reset
//   push       : write wr_data at the tail (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   rd_data    : current head entry
//   count      : registered occupancy
//   full/empty : decoded from the registered occupancy
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module router_link_fifo #(
    parameter int DATA_W = router_link_pkg::DEF_DATA_W,
    parameter int DEPTH  = router_link_pkg::DEF_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign rd_data   = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/router_link_oreq_tx.sv
// router_link_oreq_tx
// Link transmitter: buffers router flits and presents them one at a time on
// the inter-tile link as a level request plus data, retiring each flit on the
// receiver's acknowledge pulse.
//   clk, reset  : rising-edge clock, synchronous active-low reset
//   link        : flit handshake and OREQ/IACK link (master side)
//   err_clr     : clears the sticky error flags (a same-cycle set wins)
//   err_timeout : sticky, the ack wait reached ACK_TIMEOUT cycles
//   err_proto   : sticky, an ack arrived while no request was outstanding
//   fifo_count  : buffered flit count (the in-flight flit counts until acked)
//   busy        : buffer non-empty or transmitter not idle
module router_link_oreq_tx #(
    parameter int DATA_W      = router_link_pkg::DEF_DATA_W,
    parameter int FIFO_DEPTH  = router_link_pkg::DEF_FIFO_DEPTH,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                                            clk,
    input  logic                                            reset,
    router_link_oreq_tx_if.master                           link,
    input  logic                                            err_clr,
    output logic                                            err_timeout,
    output logic                                            err_proto,
    output logic [router_link_pkg::cnt_width(FIFO_DEPTH)-1:0] fifo_count,
    output logic                                            busy
);

    import router_link_pkg::*;

    localparam int CNT_W = cnt_width(FIFO_DEPTH);
    localparam int TMR_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam bit TO_EN = (ACK_TIMEOUT != 0);
    // The flag fires on the edge that moves the counter onto ACK_TIMEOUT.
    localparam logic [TMR_W-1:0] TO_M1   = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX = {TMR_W{1'b1}};

    link_tx_state_t    state_r;
    link_tx_state_t    state_nxt_s;
    logic              link_req_r;
    logic              link_req_nxt_s;
    logic [DATA_W-1:0] link_data_r;
    logic [TMR_W-1:0]  tmr_r;
    logic [TMR_W-1:0]  tmr_nxt_s;
    logic              ready_en_r;
    logic              err_timeout_r;
    logic              err_proto_r;
    logic              busy_r;
    logic              load_s;
    logic              pop_s;
    logic              push_s;
    logic              to_hit_s;
    logic              proto_hit_s;
    logic [DATA_W-1:0] head_data_s;
    logic [CNT_W-1:0]  count_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              full_s;
    logic              empty_s;

    router_link_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (link.in_data),
        .rd_data (head_data_s),
        .count   (count_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // ready_en_r keeps in_ready low through reset without a combinational
    // path from the reset pin; otherwise readiness is the registered count.
    assign link.in_ready = ready_en_r & ~full_s;
    assign push_s        = link.in_valid & link.in_ready;
    assign count_nxt_s   = count_s + CNT_W'(push_s) - CNT_W'(pop_s);

    assign link.link_req  = link_req_r;
    assign link.link_data = link_data_r;
    assign err_timeout    = err_timeout_r;
    assign err_proto      = err_proto_r;
    assign fifo_count     = count_s;
    assign busy           = busy_r;

    // Next-state, request level, head load/pop and error-event decode.
    always_comb begin
        state_nxt_s    = state_r;
        link_req_nxt_s = link_req_r;
        tmr_nxt_s      = tmr_r;
        load_s         = 1'b0;
        pop_s          = 1'b0;
        to_hit_s       = 1'b0;
        proto_hit_s    = 1'b0;
        case (state_r)
            IDLE, GAP: begin
                // No request outstanding: any ack here is a protocol error.
                tmr_nxt_s   = {TMR_W{1'b0}};
                proto_hit_s = link.link_ack;
                if (!empty_s) begin
                    state_nxt_s    = SEND;
                    link_req_nxt_s = 1'b1;
                    load_s         = 1'b1;
                end else begin
                    state_nxt_s    = IDLE;
                    link_req_nxt_s = 1'b0;
                end
            end
            SEND: begin
                if (link.link_ack) begin
                    pop_s          = 1'b1;
                    state_nxt_s    = GAP;
                    link_req_nxt_s = 1'b0;
                    tmr_nxt_s      = {TMR_W{1'b0}};
                end else begin
                    state_nxt_s    = SEND;
                    link_req_nxt_s = 1'b1;
                    if (tmr_r != TMR_MAX) begin
                        tmr_nxt_s = tmr_r + TMR_W'(1);
                    end else begin
                        tmr_nxt_s = tmr_r;
                    end
                    to_hit_s = TO_EN & (tmr_r == TO_M1);
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                link_req_nxt_s = 1'b0;
                tmr_nxt_s      = {TMR_W{1'b0}};
            end
        endcase
    end

    // State, link outputs, timeout counter, sticky errors and busy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= IDLE;
            link_req_r    <= 1'b0;
            link_data_r   <= {DATA_W{1'b0}};
            tmr_r         <= {TMR_W{1'b0}};
            ready_en_r    <= 1'b0;
            err_timeout_r <= 1'b0;
            err_proto_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            link_req_r <= link_req_nxt_s;
            tmr_r      <= tmr_nxt_s;
            ready_en_r <= 1'b1;
            // Data only moves on entry to SEND, so it is stable under req.
            if (load_s) begin
                link_data_r <= head_data_s;
            end else begin
                link_data_r <= link_data_r;
            end
            err_timeout_r <= to_hit_s | (err_timeout_r & ~err_clr);
            err_proto_r   <= proto_hit_s | (err_proto_r & ~err_clr);
            busy_r        <= (count_nxt_s != {CNT_W{1'b0}}) | (state_nxt_s != IDLE);
        end
    end

endmodule

// File: tb/tb_router_link_oreq_tx.sv
// Self-checking bench for router_link_oreq_tx: directed scenarios with
// hand-computed expectations, then randomized traffic, all compared each
// cycle against a queue-based behavioural model of the link protocol.
module tb_router_link_oreq_tx;

    localparam int DW      = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic          clk;
    logic          reset;
    logic          err_clr;
    logic          err_timeout;
    logic          err_proto;
    logic [2:0]    fifo_count;
    logic          busy;

    router_link_oreq_tx_if #(.DATA_W(DW)) lif ();

    router_link_oreq_tx #(
        .DATA_W      (DW),
        .FIFO_DEPTH  (DEPTH),
        .ACK_TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .link        (lif),
        .err_clr     (err_clr),
        .err_timeout (err_timeout),
        .err_proto   (err_proto),
        .fifo_count  (fifo_count),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: the buffered flits as a queue, the link as a
    // request level with its data, plus a one-cycle quiet marker after an ack.
    logic [DW-1:0] m_q[$];
    bit            m_req;
    bit            m_gap;
    logic [DW-1:0] m_data;
    int            m_wait;
    bit            m_err_to;
    bit            m_err_pr;
    bit            m_ready_en;
    bit            m_busy;

    logic [DW-1:0] seen_q[$];
    bit            rec_en   = 1'b0;
    logic          prev_req = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit push;
        bit set_to;
        bit set_pr;
        if (!reset) begin
            m_q.delete();
            m_req      = 1'b0;
            m_gap      = 1'b0;
            m_data     = '0;
            m_wait     = 0;
            m_err_to   = 1'b0;
            m_err_pr   = 1'b0;
            m_ready_en = 1'b0;
            m_busy     = 1'b0;
            return;
        end
        push   = lif.in_valid && m_ready_en && (m_q.size() < DEPTH);
        set_to = 1'b0;
        set_pr = 1'b0;
        if (m_req) begin
            if (lif.link_ack) begin
                void'(m_q.pop_front());
                m_req  = 1'b0;
                m_gap  = 1'b1;
                m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) set_to = 1'b1;
            end
        end else begin
            if (lif.link_ack) set_pr = 1'b1;
            m_gap = 1'b0;
            if (m_q.size() > 0) begin
                m_req  = 1'b1;
                m_data = m_q[0];
            end
        end
        m_err_to = set_to | (m_err_to & !err_clr);
        m_err_pr = set_pr | (m_err_pr & !err_clr);
        if (push) m_q.push_back(lif.in_data);
        m_busy     = (m_q.size() > 0) || m_req || m_gap;
        m_ready_en = 1'b1;
    endtask

    task automatic compare_model();
        chk("link_req",    64'(lif.link_req),  64'(m_req));
        chk("link_data",   64'(lif.link_data), 64'(m_data));
        chk("fifo_count",  64'(fifo_count),    64'(m_q.size()));
        chk("in_ready",    64'(lif.in_ready),  64'(m_ready_en && (m_q.size() < DEPTH)));
        chk("err_timeout", 64'(err_timeout),   64'(m_err_to));
        chk("err_proto",   64'(err_proto),     64'(m_err_pr));
        chk("busy",        64'(busy),          64'(m_busy));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
        if (rec_en && lif.link_req && !prev_req) seen_q.push_back(lif.link_data);
        prev_req = lif.link_req;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int budget;

        reset        = 1'b0;
        err_clr      = 1'b0;
        lif.in_valid = 1'b0;
        lif.in_data  = '0;
        lif.link_ack = 1'b0;

        // Reset state.
        repeat (3) tick();
        chk("rst_link_req",  64'(lif.link_req),  64'd0);
        chk("rst_in_ready",  64'(lif.in_ready),  64'd0);
        chk("rst_count",     64'(fifo_count),    64'd0);
        chk("rst_link_data", 64'(lif.link_data), 64'd0);
        chk("rst_busy",      64'(busy),          64'd0);
        reset = 1'b1;
        tick();
        chk("rel_in_ready",  64'(lif.in_ready),  64'd1);

        // Single flit through an idle block.
        lif.in_valid = 1'b1;
        lif.in_data  = 32'hA5A5_A5A5;
        tick();
        lif.in_valid = 1'b0;
        chk("single_count", 64'(fifo_count), 64'd1);
        chk("single_req0",  64'(lif.link_req), 64'd0);
        tick();
        chk("single_req1",  64'(lif.link_req), 64'd1);
        chk("single_data",  64'(lif.link_data), 64'hA5A5_A5A5);
        tick();
        lif.link_ack = 1'b1;
        tick();
        lif.link_ack = 1'b0;
        chk("single_req_low", 64'(lif.link_req), 64'd0);
        chk("single_gap_busy", 64'(busy), 64'd1);
        tick();
        chk("single_idle_busy", 64'(busy), 64'd0);
        chk("single_idle_count", 64'(fifo_count), 64'd0);

        // Ack timeout: no ack for TIMEOUT cycles after the request rises.
        lif.in_valid = 1'b1;
        lif.in_data  = 32'h0000_7777;
        tick();
        lif.in_valid = 1'b0;
        tick();
        chk("to_req_up", 64'(lif.link_req), 64'd1);
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            if (k == TIMEOUT - 1) chk("to_before", 64'(err_timeout), 64'd0);
        end
        chk("to_set",  64'(err_timeout), 64'd1);
        chk("to_hold", 64'(lif.link_req), 64'd1);
        repeat (3) tick();
        lif.link_ack = 1'b1;
        tick();
        lif.link_ack = 1'b0;
        chk("to_retired", 64'(fifo_count), 64'd0);
        tick();
        clear_errors();
        chk("to_cleared", 64'(err_timeout), 64'd0);

        // Spurious ack in IDLE.
        lif.link_ack = 1'b1;
        tick();
        lif.link_ack = 1'b0;
        chk("proto_idle", 64'(err_proto), 64'd1);
        chk("proto_idle_cnt", 64'(fifo_count), 64'd0);
        clear_errors();
        chk("proto_clr", 64'(err_proto), 64'd0);

        // Spurious ack in GAP: the ack is held for a second cycle.
        lif.in_valid = 1'b1;
        lif.in_data  = 32'h1234_5678;
        tick();
        lif.in_valid = 1'b0;
        tick();
        lif.link_ack = 1'b1;
        tick();
        chk("proto_gap_pre", 64'(err_proto), 64'd0);
        tick();
        lif.link_ack = 1'b0;
        chk("proto_gap", 64'(err_proto), 64'd1);
        chk("proto_gap_cnt", 64'(fifo_count), 64'd0);
        chk("proto_gap_data", 64'(lif.link_data), 64'h1234_5678);
        tick();
        clear_errors();

        // Back-to-back fill with ack held off, then drain in order.
        seen_q.delete();
        prev_req = lif.link_req;
        rec_en   = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            lif.in_valid = 1'b1;
            lif.in_data  = DW'(i);
            tick();
        end
        lif.in_data = DW'(5);
        chk("fill_in_ready", 64'(lif.in_ready), 64'd0);
        chk("fill_count",    64'(fifo_count),   64'd4);
        budget = 80;
        while (budget > 0 && !(seen_q.size() == 5 && !busy)) begin
            acc          = lif.in_ready;
            lif.link_ack = lif.link_req;
            tick();
            if (acc) lif.in_valid = 1'b0;
            budget--;
        end
        lif.link_ack = 1'b0;
        lif.in_valid = 1'b0;
        rec_en       = 1'b0;
        chk("fill_drain_budget", 64'(budget > 0), 64'd1);
        chk("fill_seen", 64'(seen_q.size()), 64'd5);
        for (int i = 0; i < seen_q.size(); i++) begin
            chk("fill_order", 64'(seen_q[i]), 64'(i + 1));
        end

        // Simultaneous push and pop at count 2.
        lif.in_valid = 1'b1;
        lif.in_data  = 32'h0000_00AA;
        tick();
        lif.in_data  = 32'h0000_00BB;
        tick();
        chk("pp_count2", 64'(fifo_count), 64'd2);
        lif.in_data  = 32'h0000_00CC;
        lif.link_ack = 1'b1;
        tick();
        lif.in_valid = 1'b0;
        lif.link_ack = 1'b0;
        chk("pp_count_stay", 64'(fifo_count), 64'd2);
        tick();
        chk("pp_next_b", 64'(lif.link_data), 64'h0000_00BB);
        lif.link_ack = 1'b1;
        tick();
        lif.link_ack = 1'b0;
        tick();
        chk("pp_next_c", 64'(lif.link_data), 64'h0000_00CC);
        lif.link_ack = 1'b1;
        tick();
        lif.link_ack = 1'b0;
        repeat (2) tick();

        // Reset mid-SEND with three flits queued.
        for (int i = 0; i < 3; i++) begin
            lif.in_valid = 1'b1;
            lif.in_data  = DW'(32'hD0 + i);
            tick();
        end
        lif.in_valid = 1'b0;
        chk("mrst_pre_req", 64'(lif.link_req), 64'd1);
        chk("mrst_pre_cnt", 64'(fifo_count),   64'd3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mrst_req",   64'(lif.link_req), 64'd0);
        chk("mrst_count", 64'(fifo_count),   64'd0);
        repeat (4) tick();
        chk("mrst_no_stale", 64'(lif.link_req), 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            lif.in_valid = ($urandom_range(0, 1) == 0);
            lif.in_data  = $urandom;
            lif.link_ack = (lif.link_req && ($urandom_range(0, 2) == 0)) ||
                           ($urandom_range(0, 59) == 0);
            err_clr      = ($urandom_range(0, 19) == 0);
            tick();
        end
        lif.in_valid = 1'b0;
        lif.link_ack = 1'b0;
        err_clr      = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/router_link_oreq_tx.md
# router_link_oreq_tx

Link transmitter for the router wrap slice. It buffers outgoing flits from the router output stage and drives them onto the inter-tile link with a level request (OREQ) plus data. It holds each flit until the downstream slice returns its registered input-acknowledge pulse (IACK), then retires the flit. It also flags acknowledge timeouts and protocol violations.

## Interface
Parameters:
- DATA_W, 32, flit width in bits
- FIFO_DEPTH, 4, flit buffer entries; power of 2, at least 2
- ACK_TIMEOUT, 15, cycles in SEND without ack before `err_timeout` sets; 0 disables the check

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  router offers a flit
- in_ready  output  1  buffer can accept a flit
- in_data  input  DATA_W  flit payload
- link_req  output  1  OREQ level; `link_data` is valid while high
- link_data  output  DATA_W  flit on the link; stable while `link_req` is high
- link_ack  input  1  IACK pulse from the receiver, one cycle wide
- err_clr  input  1  clears the sticky error flags
- err_timeout  output  1  sticky; set when the ack wait reaches ACK_TIMEOUT
- err_proto  output  1  sticky; set when `link_ack` arrives outside SEND
- fifo_count  output  $clog2(FIFO_DEPTH+1)  number of occupied entries
- busy  output  1  high when the FIFO is non-empty or the state is not IDLE

## Operation
- Reset (`reset`=0 at a clock edge):
  - `link_req`, `in_ready`=0 during reset, then `in_ready`=1 on the first cycle after release
  - `fifo_count`=0, `err_*`=0, state IDLE, timeout counter 0, `link_data`=0
- Acceptance: a flit is pushed when `in_valid && in_ready`.
  - `in_ready` = (`fifo_count` < FIFO_DEPTH), taken from registered count only.
  - A pop in the same cycle does not let a push into a full FIFO.
- FSM:
  - IDLE: if the FIFO is non-empty, go to SEND. Register the head flit into `link_data` and raise `link_req`.
  - SEND: hold `link_req`=1 and `link_data` stable; increment the timeout counter (saturating).
    - On `link_ack`=1, pop the head and go to GAP.
    - If the counter equals ACK_TIMEOUT (and ACK_TIMEOUT≠0), set `err_timeout` and remain in SEND, still requesting.
  - GAP: `link_req`=0 for exactly one cycle so the receiver sees a clean edge, and the counter clears. Then go to SEND if the FIFO is non-empty (load the new head), otherwise to IDLE.
- `link_ack` in IDLE or GAP: ignored for data purposes; sets `err_proto`.
- `err_clr`: clears both error flags. If a set event occurs in the same cycle, the set wins.
- Push and pop in the same cycle: `fifo_count` stays unchanged; ordering is preserved.
- Pointers wrap modulo FIFO_DEPTH.
- Reset mid-transfer: the in-flight flit and the FIFO contents are discarded; no retry.

## Timing
- A flit pushed at edge t into an empty IDLE block gives `link_req`=1 with that data from edge t+1.
- `link_ack` sampled at edge t (in SEND) gives `link_req`=0 from t+1, and the next flit's request from t+2.
- Minimum per-flit period: 3 cycles (SEND, ack at earliest the next cycle from the registered IACK, GAP).
- `link_data` changes only on transitions into SEND. It is never modified while `link_req`=1.
- `err_timeout` rises at the edge where the SEND cycle count reaches ACK_TIMEOUT. With ACK_TIMEOUT=15, a req raised at t with no ack sets the flag at t+15.
- All outputs are registered except `in_ready`, which is decoded from the registered count.

## Structure
- Package `router_link_pkg`:
  - state enum `link_tx_state_t` {IDLE, SEND, GAP}
  - default DATA_W and FIFO_DEPTH constants
  - a count-width function
- Sub-module `router_link_fifo`: synchronous FIFO with push, pop, head data, count, and full/empty. It has the same clock and reset as the top.
- The top holds the FSM, the timeout counter, the error flags, and the link output registers.

## Test plan
- Single flit: push 0xA5A5A5A5 at t0 → `link_req`=1 with that data at t1; ack at t3 → req low at t4, IDLE and `busy`=0 at t5.
- Back-to-back fill: push 5 flits with FIFO_DEPTH=4 and ack held off → `in_ready`=0 after 4 pushes; flits exit in order 1..5 with one GAP cycle between requests.
- Timeout: req raised, no ack for 15 cycles → `err_timeout`=1 at req+15 and req stays high; a later ack retires the flit; `err_clr` clears the flag.
- Spurious ack: pulse `link_ack` in IDLE and again in GAP → `err_proto`=1, `fifo_count` and data unaffected.
- Simultaneous push/pop at count=2 → count stays 2 and ordering is intact.
- Reset mid-SEND with 3 queued → next cycle `link_req`=0 and `fifo_count`=0; no stale flit after release.
